// File: rtl/jt51_i2s_tx.sv
// I2S / left-justified serial transmitter for the accumulator's 16-bit stereo output.
// Self-generated bclk/lrck, with a one-entry hold buffer and overrun/underrun pulses.
module jt51_i2s_tx #(
  parameter int unsigned DIV  = 4,
  parameter int unsigned WORD = 32,
  parameter bit          LJ   = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample,
  input  logic [15:0] left_in,
  input  logic [15:0] right_in,
  output logic        bclk,
  output logic        lrck,
  output logic        sdata,
  output logic        overrun,
  output logic        underrun
);

  localparam int unsigned FW = 2 * WORD;
  localparam int unsigned SW = $clog2(FW);
  localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [SW-1:0] S_LAST   = SW'(FW - 1);
  localparam logic [SW-1:0] S_HALF   = SW'(WORD);

  if (DIV < 1 || WORD < 16 || WORD > 32) begin : g_bad_param
    $error("jt51_i2s_tx: illegal parameters DIV=%0d WORD=%0d", DIV, WORD);
  end

  logic [DW-1:0] r_div;
  logic [SW-1:0] r_s;
  logic [FW-1:0] r_sh;
  logic          r_bclk, r_lrck, r_sdata, r_ovr, r_unr;
  logic [15:0]   r_hl, r_hr, r_ll, r_lr;
  logic          r_full, r_primed;

  logic          w_wrap, w_fall, w_fstart;
  logic [SW-1:0] w_s_nxt;
  logic [15:0]   w_ld_l, w_ld_r;
  logic [FW-1:0] w_frame, w_sh_nxt;

  assign w_wrap   = (r_div == DIV_LAST);
  assign w_fall   = w_wrap & r_bclk;
  assign w_fstart = w_fall & (r_s == S_LAST);
  assign w_s_nxt  = w_fstart ? '0 : r_s + 1'b1;

  // Frame source priority: held pair, then a same-cycle bypass, else repeat the last pair.
  always_comb begin
    w_ld_l = r_ll;
    w_ld_r = r_lr;
    if (r_full) begin
      w_ld_l = r_hl;
      w_ld_r = r_hr;
    end else if (sample) begin
      w_ld_l = left_in;
      w_ld_r = right_in;
    end
    w_frame = '0;
    w_frame[FW-1 -: 16]   = w_ld_l;
    w_frame[WORD-1 -: 16] = w_ld_r;
    w_sh_nxt = w_fstart ? w_frame : {r_sh[FW-2:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div    <= '0;
      r_s      <= '0;
      r_sh     <= '0;
      r_bclk   <= 1'b0;
      r_lrck   <= 1'b0;
      r_sdata  <= 1'b0;
      r_ovr    <= 1'b0;
      r_unr    <= 1'b0;
      r_hl     <= '0;
      r_hr     <= '0;
      r_ll     <= '0;
      r_lr     <= '0;
      r_full   <= 1'b0;
      r_primed <= 1'b0;
    end else begin
      r_ovr <= 1'b0;
      r_unr <= 1'b0;
      r_div <= w_wrap ? '0 : r_div + 1'b1;
      if (w_wrap) r_bclk <= ~r_bclk;
      if (w_fall) begin
        r_s    <= w_s_nxt;
        r_lrck <= (w_s_nxt >= S_HALF);
        r_sh   <= w_sh_nxt;
        // I2S reuses the output register as the one-slot delay.
        r_sdata <= LJ ? w_sh_nxt[FW-1] : r_sh[FW-1];
      end
      if (sample) r_primed <= 1'b1;
      if (w_fstart) begin
        r_ll <= w_ld_l;
        r_lr <= w_ld_r;
        if (r_full) begin
          if (sample) begin
            r_hl <= left_in;
            r_hr <= right_in;
          end else begin
            r_full <= 1'b0;
          end
        end else if (!sample && r_primed) begin
          r_unr <= 1'b1;
        end
      end else if (sample) begin
        r_hl   <= left_in;
        r_hr   <= right_in;
        r_full <= 1'b1;
        r_ovr  <= r_full;
      end
    end
  end

  assign bclk     = r_bclk;
  assign lrck     = r_lrck;
  assign sdata    = r_sdata;
  assign overrun  = r_ovr;
  assign underrun = r_unr;

endmodule

// File: tb/tb_jt51_i2s_tx.sv
// Directed bench for jt51_i2s_tx: one LJ/DIV=1/WORD=16 instance and one I2S/DIV=2/WORD=32
// instance, each exercised while the other is held in reset.
module tb_jt51_i2s_tx;

  logic        clk = 1'b0;
  logic        rst_a, rst_b, sample;
  logic [15:0] left_in, right_in;
  logic        bclk_a, lrck_a, sdata_a, ovr_a, unr_a;
  logic        bclk_b, lrck_b, sdata_b, ovr_b, unr_b;
  logic        sel;
  logic        sd, lr, ov, un;

  int errors = 0;
  int checks = 0;
  int k = 0;
  logic g_slot [0:63];
  logic g_lr   [0:63];
  int   g_ov, g_un;
  logic [15:0] g_l, g_r;
  logic        g_z;

  always #5 clk = ~clk;

  jt51_i2s_tx #(.DIV(1), .WORD(16), .LJ(1'b1)) u_a (
    .clk(clk), .rst(rst_a), .sample(sample), .left_in(left_in), .right_in(right_in),
    .bclk(bclk_a), .lrck(lrck_a), .sdata(sdata_a), .overrun(ovr_a), .underrun(unr_a)
  );

  jt51_i2s_tx #(.DIV(2), .WORD(32), .LJ(1'b0)) u_b (
    .clk(clk), .rst(rst_b), .sample(sample), .left_in(left_in), .right_in(right_in),
    .bclk(bclk_b), .lrck(lrck_b), .sdata(sdata_b), .overrun(ovr_b), .underrun(unr_b)
  );

  assign sd = sel ? sdata_b : sdata_a;
  assign lr = sel ? lrck_b  : lrck_a;
  assign ov = sel ? ovr_b   : ovr_a;
  assign un = sel ? unr_b   : unr_a;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clk step; sample is a single-clk strobe so it is always dropped here.
  task automatic tick();
    @(posedge clk);
    #1;
    sample = 1'b0;
    k++;
  endtask

  task automatic run_to(input int n);
    while (k < n) tick();
  endtask

  task automatic strobe(input logic [15:0] l, input logic [15:0] r);
    sample   = 1'b1;
    left_in  = l;
    right_in = r;
  endtask

  // Called one clk before a frame start; records each slot's sdata/lrck and counts flags.
  task automatic grab();
    int per = sel ? 2 : 1;
    int fw  = sel ? 64 : 32;
    g_ov = 0;
    g_un = 0;
    for (int j = 0; j < fw; j++) begin
      for (int c = 0; c < 2 * per; c++) begin
        tick();
        if (c == 0) begin
          g_slot[j] = sd;
          g_lr[j]   = lr;
        end
        g_ov += int'(ov);
        g_un += int'(un);
      end
    end
  endtask

  task automatic extract(input int d, input int w);
    g_l = '0;
    g_r = '0;
    g_z = 1'b0;
    for (int i = 0; i < 16; i++) begin
      g_l[15-i] = g_slot[d+i];
      g_r[15-i] = g_slot[w+d+i];
    end
    for (int i = d + 16; i < w; i++) g_z = g_z | g_slot[i];
  endtask

  initial begin
    sel = 1'b0; rst_a = 1'b1; rst_b = 1'b1;
    sample = 1'b0; left_in = '0; right_in = '0;
    repeat (3) tick();
    chk("a_rst_bclk", bclk_a, 0);
    chk("a_rst_lrck", lrck_a, 0);
    chk("a_rst_sdata", sdata_a, 0);
    chk("a_rst_ovr", ovr_a, 0);
    chk("a_rst_unr", unr_a, 0);
    chk("b_rst_bclk", bclk_b, 0);

    // DUT A: two idle frames, bclk every clk, lrck period 64 clk, no underrun before priming.
    rst_a = 1'b0;
    k = 0;
    for (int i = 1; i < 128; i++) begin
      tick();
      chk("a_idle_bclk", bclk_a, k & 1);
      chk("a_idle_lrck", lrck_a, ((k >> 1) & 31) >= 16);
      chk("a_idle_sdata", sdata_a, 0);
      chk("a_idle_unr", unr_a, 0);
    end

    run_to(129);
    strobe(16'h8001, 16'h7FFE);
    tick();
    chk("a_s1_ovr", ovr_a, 0);
    run_to(191);
    grab();
    extract(0, 16);
    chk("a_f3_left", g_l, 16'h8001);
    chk("a_f3_right", g_r, 16'h7FFE);
    chk("a_f3_lrck0", g_lr[0], 0);
    chk("a_f3_lrck16", g_lr[16], 1);
    chk("a_f3_ovr", g_ov, 0);
    chk("a_f3_unr", g_un, 0);

    // Frame 4 starts with the buffer drained.
    tick();
    chk("a_f4_unr", unr_a, 1);
    tick();
    chk("a_f4_unr_end", unr_a, 0);

    run_to(259);
    strobe(16'h0001, 16'h0000);
    tick();
    chk("a_ovr_first", ovr_a, 0);
    run_to(269);
    strobe(16'h0002, 16'h0000);
    tick();
    chk("a_ovr_pulse", ovr_a, 1);
    tick();
    chk("a_ovr_end", ovr_a, 0);

    run_to(319);
    grab();
    extract(0, 16);
    chk("a_f5_left", g_l, 16'h0002);
    chk("a_f5_ovr", g_ov, 0);
    chk("a_f5_unr", g_un, 0);

    grab();
    extract(0, 16);
    chk("a_f6_left", g_l, 16'h0002);
    chk("a_f6_unr", g_un, 1);

    // Strobe lands exactly on the frame-7 start with the buffer empty.
    strobe(16'h1234, 16'hBEEF);
    grab();
    extract(0, 16);
    chk("a_f7_left", g_l, 16'h1234);
    chk("a_f7_right", g_r, 16'hBEEF);
    chk("a_f7_ovr", g_ov, 0);
    chk("a_f7_unr", g_un, 0);

    // DUT B: I2S, DIV=2, WORD=32.
    rst_a = 1'b1;
    sel = 1'b1;
    tick();
    rst_b = 1'b0;
    k = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("b_start_bclk", bclk_b, (k >> 1) & 1);
      chk("b_start_lrck", lrck_b, 0);
      chk("b_start_sdata", sdata_b, 0);
    end
    run_to(9);
    strobe(16'hA5A5, 16'h5A5A);
    tick();
    chk("b_s_ovr", ovr_b, 0);
    run_to(255);
    grab();
    extract(1, 32);
    chk("b_f1_left", g_l, 16'hA5A5);
    chk("b_f1_right", g_r, 16'h5A5A);
    chk("b_f1_pad", g_z, 0);
    chk("b_f1_slot0", g_slot[0], 0);
    chk("b_f1_lrck0", g_lr[0], 0);
    chk("b_f1_lrck31", g_lr[31], 0);
    chk("b_f1_lrck32", g_lr[32], 1);
    chk("b_f1_unr", g_un, 0);
    tick();
    chk("b_f2_unr", unr_b, 1);

    // Reset in the middle of a right slot carrying a 1 bit.
    run_to(700);
    chk("b_pre_lrck", lrck_b, 1);
    chk("b_pre_sdata", sdata_b, 1);
    rst_b = 1'b1;
    tick();
    chk("b_mid_bclk", bclk_b, 0);
    chk("b_mid_lrck", lrck_b, 0);
    chk("b_mid_sdata", sdata_b, 0);
    rst_b = 1'b0;
    k = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("b_re_bclk", bclk_b, (k >> 1) & 1);
      chk("b_re_lrck", lrck_b, 0);
      chk("b_re_sdata", sdata_b, 0);
    end
    run_to(255);
    grab();
    extract(1, 32);
    chk("b_re_left", g_l, 16'h0000);
    chk("b_re_right", g_r, 16'h0000);
    chk("b_re_unr", g_un, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jt51_i2s_tx.md
# jt51_i2s_tx

Serial audio transmitter that sits directly downstream of the accumulator. It captures the exact 16-bit left/right samples each time the accumulator publishes a new pair. It re-times them into a continuous I2S or left-justified bit stream with self-generated bit clock and word clock. A one-entry holding buffer decouples the chip's sample cadence from the serial frame rate, and flags report overrun and underrun.

## Interface
- DIV, 4: bclk half-period in clk cycles; legal range ≥1.
- WORD, 32: bclk slots per channel; legal range 16..32. The sample is sent MSB first and followed by WORD-16 zero bits.
- LJ, 0: 0 = I2S (data delayed one slot after lrck edge); 1 = left-justified.

- clk  input  1  system clock; every register is clocked on the rising edge.
- rst  input  1  synchronous, active-high reset.
- sample  input  1  new-pair strobe, one clk wide. Driven by c1_enters & cen upstream.
- left_in  input  16  signed left sample, valid while sample=1.
- right_in  input  16  signed right sample, valid while sample=1.
- bclk  output  1  bit clock, 50% duty, period 2*DIV clk.
- lrck  output  1  word clock: 0 = left slot, 1 = right slot.
- sdata  output  1  serial data, changes only on bclk falling edges.
- overrun  output  1  one-clk pulse when a sample arrives while the hold buffer is full.
- underrun  output  1  one-clk pulse when a frame starts with the hold buffer empty. Suppressed until the first sample after reset.

## Operation
- The divider counts clk cycles 0..DIV-1 and runs independently of cen. On wrap, bclk toggles.
- A falling event is a toggle 1→0. On a falling event, slot counter s advances modulo 2*WORD.
- lrck = (s ≥ WORD).
- Frame start is a falling event that takes s from 2*WORD-1 to 0.
- Frame contents: the shift register is loaded with {L[15:0], (WORD-16)'b0, R[15:0], (WORD-16)'b0}.
- Left-justified bit: b = frame bit (2*WORD-1-s).
- I2S mode: sdata is b delayed by one slot through a 1-bit register updated on falling events. The left MSB therefore appears in slot 1, and the last bit of the previous frame appears in slot 0.
- Hold buffer: registers hl, hr and flag full.
  - On sample with no frame start: hl/hr ← inputs. If full=1, pulse overrun; the newest pair wins. Then full ← 1 and primed ← 1.
  - On frame start with full=1: the shifter loads hl/hr and full ← 0.
  - On frame start with full=0: the shifter reloads the last transmitted pair. If primed=1, pulse underrun.
  - Simultaneous sample and frame start, full=1: the shifter takes the old hl/hr, the hold buffer takes the new pair, full stays 1, no overrun.
  - Simultaneous sample and frame start, full=0: the new pair bypasses straight into the shifter, full stays 0, no underrun.
- Samples pass through bit-exact; there is no clamping or scaling.

## Timing
- Reset values: bclk=0, lrck=0, sdata=0, overrun=0, underrun=0, divider=0, s=0, full=0, primed=0. The shifter, last pair and delay bit are all 0.
- After reset the block is in slot 0 of an all-zero frame.
  - First bclk rise: DIV clk after reset release.
  - First falling event: 2*DIV clk after release.
  - First frame start: 4*DIV*WORD clk after release.
- All outputs are registered. Each bclk, lrck and sdata change is visible one clk after the divider wrap that causes it; the three change in the same clk.
- Latency from sample to left MSB on sdata: frame start + LJ?0:2*DIV clk. The worst case is one full frame plus that.
- rst mid-frame: the frame is abandoned immediately and all state returns to reset values. No partial-word glitch beyond the reset cycle is allowed.
- Parameter combinations outside the legal ranges are unsupported. The simulation model must $error on them.

## Test plan
- Reset, LJ=1, DIV=1, WORD=16, no samples -> bclk toggles every clk; lrck period 64 clk; sdata stays 0; underrun never pulses.
- LJ=1, WORD=16, sample L=16'h8001, R=16'h7FFE before frame 1 -> left slots read 1000…0001 and right slots 0111…1110, MSB first. No flags.
- LJ=0, WORD=32, L=16'hA5A5 -> the MSB appears in slot 1 after lrck falls; slots 17..31 are 0; the right MSB appears one slot after lrck rises.
- Two samples inside one frame (L=1 then L=2) -> overrun pulses once and the next frame sends L=2. A following frame with no new sample sends L=2 again and underrun pulses once.
- Sample strobe coincident with frame start, full=0, L=16'h1234 -> that same frame carries 16'h1234; no underrun, no overrun.
- Assert rst mid-right-slot -> next clk bclk=lrck=sdata=0. The restart timing matches the first test exactly.
